// File: rtl/preg_pkg.sv
// Shared types for the elastic pipeline register: occupancy state and count width.
package preg_pkg;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } preg_state_t;
endpackage

// File: rtl/preg_elastic_slot.sv
// One pipeline entry (valid + ctrl + payload) with flush, load, drop-to-bubble and hold.
module preg_slot
  import preg_pkg::*;
#(
  parameter int CTRL_WIDTH          = 16,
  parameter int DATA_WIDTH          = 64,
  parameter int CLEAR_DATA_ON_FLUSH = 0
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  drop,
  input  logic [CTRL_WIDTH-1:0] load_ctrl,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);
  localparam bit CLEAR_DATA = CLEAR_DATA_ON_FLUSH[0];

  logic                  valid_r;
  logic [CTRL_WIDTH-1:0] ctrl_r;
  logic [DATA_WIDTH-1:0] data_r;

  // Entry register; a bubble always carries all-zero control lanes.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_WIDTH{1'b0}};
      data_r  <= {DATA_WIDTH{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_WIDTH{1'b0}};
      if (CLEAR_DATA) begin
        data_r <= {DATA_WIDTH{1'b0}};
      end else begin
        data_r <= data_r;
      end
    end else if (load) begin
      valid_r <= 1'b1;
      ctrl_r  <= load_ctrl;
      data_r  <= load_data;
    end else if (drop) begin
      // Payload is left untouched on a bubble to avoid needless toggling.
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_WIDTH{1'b0}};
      data_r  <= data_r;
    end else begin
      valid_r <= valid_r;
      ctrl_r  <= ctrl_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign ctrl  = ctrl_r;
  assign data  = data_r;
endmodule

// File: rtl/preg_elastic.sv
// Elastic pipeline register with valid/ready handshake, flush-to-NOP and optional skid entry.
module preg_elastic
  import preg_pkg::*;
#(
  parameter int CTRL_WIDTH          = 16,
  parameter int DATA_WIDTH          = 64,
  parameter int SKID                = 1,
  parameter int CLEAR_DATA_ON_FLUSH = 0
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_W-1:0]      o_count
);
  localparam bit HAS_SKID = SKID[0];

  preg_state_t           state_r, state_s;
  logic                  ready_r;
  logic                  accept_s, consume_s;
  logic                  main_load_s, main_drop_s, main_from_skid_s;
  logic                  skid_load_s, skid_drop_s;
  logic                  main_valid_s, skid_valid_s;
  logic [CTRL_WIDTH-1:0] main_ctrl_in_s, skid_ctrl_s;
  logic [DATA_WIDTH-1:0] main_data_in_s, skid_data_s;

  assign o_ready   = HAS_SKID ? ready_r : (~main_valid_s | i_ready);
  assign accept_s  = i_valid & o_ready & ~i_flush;
  assign consume_s = main_valid_s & i_ready;

  // Occupancy state and registered ready (ready is low out of reset until the first edge).
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r <= ST_EMPTY;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s != ST_TWO);
    end
  end

  // Next-state and slot control; the single-entry build never reaches ST_TWO since it
  // only accepts in ST_ONE when the downstream consumes.
  always_comb begin
    state_s          = state_r;
    main_load_s      = 1'b0;
    main_drop_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_drop_s      = 1'b0;
    if (i_flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_s     = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && consume_s) begin
            main_load_s = 1'b1;
          end else if (accept_s) begin
            state_s     = ST_TWO;
            skid_load_s = 1'b1;
          end else if (consume_s) begin
            state_s     = ST_EMPTY;
            main_drop_s = 1'b1;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (consume_s) begin
            state_s          = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_drop_s      = 1'b1;
          end else begin
            state_s = ST_TWO;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Main entry refills from the skid entry when draining ST_TWO, otherwise from upstream.
  always_comb begin
    main_ctrl_in_s = i_ctrl;
    main_data_in_s = i_data;
    if (main_from_skid_s && skid_valid_s) begin
      main_ctrl_in_s = skid_ctrl_s;
      main_data_in_s = skid_data_s;
    end else begin
      main_ctrl_in_s = i_ctrl;
      main_data_in_s = i_data;
    end
  end

  preg_slot #(
    .CTRL_WIDTH         (CTRL_WIDTH),
    .DATA_WIDTH         (DATA_WIDTH),
    .CLEAR_DATA_ON_FLUSH(CLEAR_DATA_ON_FLUSH)
  ) u_main (
    .clk      (i_clk),
    .arst     (i_arst),
    .flush    (i_flush),
    .load     (main_load_s),
    .drop     (main_drop_s),
    .load_ctrl(main_ctrl_in_s),
    .load_data(main_data_in_s),
    .valid    (main_valid_s),
    .ctrl     (o_ctrl),
    .data     (o_data)
  );

  generate
    if (HAS_SKID) begin : g_skid
      preg_slot #(
        .CTRL_WIDTH         (CTRL_WIDTH),
        .DATA_WIDTH         (DATA_WIDTH),
        .CLEAR_DATA_ON_FLUSH(1)
      ) u_skid (
        .clk      (i_clk),
        .arst     (i_arst),
        .flush    (i_flush),
        .load     (skid_load_s),
        .drop     (skid_drop_s),
        .load_ctrl(i_ctrl),
        .load_data(i_data),
        .valid    (skid_valid_s),
        .ctrl     (skid_ctrl_s),
        .data     (skid_data_s)
      );
    end else begin : g_no_skid
      assign skid_valid_s = 1'b0;
      assign skid_ctrl_s  = {CTRL_WIDTH{1'b0}};
      assign skid_data_s  = {DATA_WIDTH{1'b0}};
    end
  endgenerate

  assign o_valid = main_valid_s;
  assign o_count = state_r;
endmodule

// File: tb/tb_preg_elastic.sv
// Directed and scoreboard bench for preg_elastic: a SKID=1 instance with payload clear on flush
// and a SKID=0 instance with payload held on flush.
module tb_preg_elastic;
  localparam int CW = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic          d_flush, d_valid, d_ready, q_ready, q_valid;
  logic [CW-1:0] d_ctrl, q_ctrl;
  logic [DW-1:0] d_data, q_data;
  logic [1:0]    q_count;

  logic          z_flush, z_valid, z_ready, z_o_ready, z_q_valid;
  logic [CW-1:0] z_ctrl, z_q_ctrl;
  logic [DW-1:0] z_data, z_q_data;
  logic [1:0]    z_q_count;

  preg_elastic #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1), .CLEAR_DATA_ON_FLUSH(1)) dut (
    .i_clk(clk), .i_arst(arst), .i_flush(d_flush), .i_valid(d_valid), .o_ready(q_ready),
    .i_ctrl(d_ctrl), .i_data(d_data), .o_valid(q_valid), .i_ready(d_ready),
    .o_ctrl(q_ctrl), .o_data(q_data), .o_count(q_count)
  );

  preg_elastic #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(0), .CLEAR_DATA_ON_FLUSH(0)) dut0 (
    .i_clk(clk), .i_arst(arst), .i_flush(z_flush), .i_valid(z_valid), .o_ready(z_o_ready),
    .i_ctrl(z_ctrl), .i_data(z_data), .o_valid(z_q_valid), .i_ready(z_ready),
    .o_ctrl(z_q_ctrl), .o_data(z_q_data), .o_count(z_q_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          v, r, f;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic          cd;
    logic [1:0]    en;
    logic          er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, r, f, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic ev, input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                     input logic cd, input logic [1:0] en, input logic er);
    vec_t t;
    t.v = v; t.r = r; t.f = f; t.c = c; t.d = d;
    t.ev = ev; t.ec = ec; t.ed = ed; t.cd = cd; t.en = en; t.er = er;
    tbl.push_back(t);
  endtask

  // Stall monitor: when the stage holds a beat under back-pressure, outputs must not move.
  always @(posedge clk) begin : stall_mon
    logic          hold;
    logic [CW-1:0] c0;
    logic [DW-1:0] d0;
    hold = !arst && q_valid && !d_ready && !d_flush;
    c0 = q_ctrl;
    d0 = q_data;
    #1;
    if (hold && !arst) begin
      chk("stall_valid", q_valid, 1'b1);
      chk("stall_ctrl", q_ctrl, c0);
      chk("stall_data", q_data, d0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] sbq[$];
    logic [63:0] seq;
    logic        acc, cons;
    logic [63:0] exp_d;

    arst = 1'b1;
    d_flush = 1'b0; d_valid = 1'b0; d_ready = 1'b1; d_ctrl = '0; d_data = '0;
    z_flush = 1'b0; z_valid = 1'b0; z_ready = 1'b1; z_ctrl = '0; z_data = '0;
    #1;
    chk("rst_valid", q_valid, 1'b0);
    chk("rst_ctrl", q_ctrl, 16'h0);
    chk("rst_data", q_data, 64'h0);
    chk("rst_count", q_count, 2'd0);
    #11 arst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", q_ready, 1'b1);

    // Streaming, one beat per cycle.
    for (int i = 0; i < 8; i++)
      add(1'b1, 1'b1, 1'b0, 16'(i + 1), 64'h10 + 64'(i), 1'b1, 16'(i + 1), 64'h10 + 64'(i), 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 64'h0, 1'b0, 2'd0, 1'b1);
    // Stall: 0xA1 goes to skid, 0xA2 offered while full is refused.
    add(1'b1, 1'b1, 1'b0, 16'h00A0, 64'hA0, 1'b1, 16'h00A0, 64'hA0, 1'b1, 2'd1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 16'h00A1, 64'hA1, 1'b1, 16'h00A0, 64'hA0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b1, 1'b0, 1'b0, 16'h00A2, 64'hA2, 1'b1, 16'h00A0, 64'hA0, 1'b1, 2'd2, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0, 64'h0, 1'b1, 16'h00A1, 64'hA1, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 64'h0, 1'b0, 2'd0, 1'b1);
    // Flush at count=2 with a beat offered; payload cleared in this build.
    add(1'b1, 1'b0, 1'b0, 16'h00B0, 64'hB0, 1'b1, 16'h00B0, 64'hB0, 1'b1, 2'd1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 16'h00B1, 64'hB1, 1'b1, 16'h00B0, 64'hB0, 1'b1, 2'd2, 1'b0);
    add(1'b1, 1'b0, 1'b1, 16'h00B2, 64'hB2, 1'b0, 16'h0, 64'h0, 1'b1, 2'd0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 64'h0, 1'b1, 2'd0, 1'b1);
    // Flush together with a consume.
    add(1'b1, 1'b1, 1'b0, 16'h00C0, 64'hC0, 1'b1, 16'h00C0, 64'hC0, 1'b1, 2'd1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 16'h00C1, 64'hC1, 1'b0, 16'h0, 64'h0, 1'b1, 2'd0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 16'h00C2, 64'hC2, 1'b1, 16'h00C2, 64'hC2, 1'b1, 2'd1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 64'h0, 1'b0, 2'd0, 1'b1);

    foreach (tbl[i]) begin
      d_valid = tbl[i].v; d_ready = tbl[i].r; d_flush = tbl[i].f;
      d_ctrl = tbl[i].c; d_data = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), q_valid, tbl[i].ev);
      chk($sformatf("vec%0d_ctrl", i), q_ctrl, tbl[i].ec);
      if (tbl[i].cd) chk($sformatf("vec%0d_data", i), q_data, tbl[i].ed);
      chk($sformatf("vec%0d_count", i), q_count, tbl[i].en);
      chk($sformatf("vec%0d_ready", i), q_ready, tbl[i].er);
    end
    d_flush = 1'b0;

    // Async reset while two beats are held.
    d_valid = 1'b1; d_ready = 1'b0; d_ctrl = 16'h00D0; d_data = 64'hD0;
    @(posedge clk); #1;
    d_ctrl = 16'h00D1; d_data = 64'hD1;
    @(posedge clk); #1;
    chk("pre_rst_count", q_count, 2'd2);
    d_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk("midrst_valid", q_valid, 1'b0);
    chk("midrst_ctrl", q_ctrl, 16'h0);
    chk("midrst_data", q_data, 64'h0);
    chk("midrst_count", q_count, 2'd0);
    @(negedge clk) arst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", q_ready, 1'b1);
    d_valid = 1'b1; d_ctrl = 16'h00E0; d_data = 64'hE0;
    @(posedge clk); #1;
    chk("after_rst_data", q_data, 64'hE0);
    chk("after_rst_count", q_count, 2'd1);
    d_valid = 1'b0; d_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_drain_valid", q_valid, 1'b0);
    chk("after_rst_drain_count", q_count, 2'd0);

    // SKID=0: combinational ready and payload held across flush.
    z_valid = 1'b1; z_ready = 1'b0; z_ctrl = 16'h0055; z_data = 64'h55;
    @(posedge clk); #1;
    chk("s0_load_valid", z_q_valid, 1'b1);
    chk("s0_load_data", z_q_data, 64'h55);
    chk("s0_ready_low", z_o_ready, 1'b0);
    z_valid = 1'b0; z_ready = 1'b1;
    #1;
    chk("s0_ready_high", z_o_ready, 1'b1);
    z_flush = 1'b1;
    @(posedge clk); #1;
    chk("s0_flush_valid", z_q_valid, 1'b0);
    chk("s0_flush_ctrl", z_q_ctrl, 16'h0);
    chk("s0_flush_data_held", z_q_data, 64'h55);
    chk("s0_flush_count", z_q_count, 2'd0);
    z_flush = 1'b0;

    // SKID=0 random valid/ready against a FIFO scoreboard.
    seq = 64'h100;
    for (int k = 0; k < 10003; k++) begin
      z_valid = (k < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      z_ready = (k < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      z_data = seq;
      z_ctrl = seq[15:0];
      #1;
      acc  = z_valid & z_o_ready;
      cons = z_q_valid & z_ready;
      if (!z_q_valid) chk("s0_bubble_ctrl", z_q_ctrl, 16'h0);
      if (cons) begin
        chk("s0_sb_nonempty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          exp_d = sbq.pop_front();
          chk("s0_sb_data", z_q_data, exp_d);
          chk("s0_sb_ctrl", z_q_ctrl, exp_d[15:0]);
        end
      end
      if (acc) begin
        sbq.push_back(seq);
        seq = seq + 64'd1;
      end
      @(posedge clk); #1;
    end
    chk("s0_sb_drained", 64'(sbq.size()), 64'd0);
    chk("s0_final_valid", z_q_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
